ifetch_prefetch: RTL

Instruction fetch front end for the rv32 core, sitting directly upstream of the core's decode/execute stage and downstream of instruction memory. It holds the fetch PC, issues sequential word requests to instruction memory over a request/grant, in-order response bus, and buffers returned instructions with their PCs in a small FIFO. The core consumes instructions through a valid/ready handshake. A taken branch or jump from execute redirects fetch, flushing all buffered and in-flight instructions.

---
 rtl/ifetch_prefetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: rv32 instruction fetch front end.
// Holds the fetch PC, issues sequential word requests to instruction memory,
// tracks in-flight request PCs, and buffers returned words in a small FIFO
// delivered to decode through a valid/ready handshake. A redirect flushes
// buffered and in-flight work; late responses to flushed requests are
// discarded through the kill counter.
// Optional feature macro: IFETCH_BYPASS_EN (a live response reaching an empty
// FIFO drives the output in the same cycle).
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  ptr_t        ifq_wr_q, ifq_wr_d, ifq_rd_q, ifq_rd_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        kill_q, kill_d;

  logic [31:0] fifo_inst_mem [DEPTH];
  logic [31:0] fifo_pc_mem   [DEPTH];
  logic [31:0] ifq_pc_mem    [DEPTH];

  logic [CW:0] credit_used;
  logic        grant, rsp_live, rsp_dead, fifo_empty;
  logic        bypass, xfer, pop, push;
  logic        unused_redirect_lsb;

  // The low PC bits of a redirect target are architecturally zero.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request side depends on registered state only (plus reset gating).
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req    = rst_n & (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc_q;

  assign grant      = imem_req & imem_gnt;
  assign rsp_live   = imem_rvalid & (kill_q == '0);
  assign rsp_dead   = imem_rvalid & (kill_q != '0);
  assign fifo_empty = (count_q == '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = fifo_empty & rsp_live & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = ~fifo_empty | bypass;
  assign inst       = !fifo_empty ? fifo_inst_mem[fifo_rd_q] :
                      (bypass ? imem_rdata : 32'h0);
  assign inst_pc    = !fifo_empty ? fifo_pc_mem[fifo_rd_q] :
                      (bypass ? ifq_pc_mem[ifq_rd_q] : 32'h0);

  assign xfer = inst_valid & inst_ready;
  assign pop  = xfer & ~fifo_empty;
  // A bypassed word taken by the consumer never enters the FIFO.
  assign push = rsp_live & ~redirect & ~(bypass & inst_ready);

  // Next-state: grants, responses and pops; a redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    ifq_wr_d      = ifq_wr_q;
    ifq_rd_d      = ifq_rd_q;
    count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(imem_rvalid);
    kill_d        = kill_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      ifq_wr_d   = ifq_wr_q + ptr_t'(1);
    end
    if (rsp_live) ifq_rd_d = ifq_rd_q + ptr_t'(1);
    if (rsp_dead) kill_d = kill_q - cnt_t'(1);
    if (push) fifo_wr_d = fifo_wr_q + ptr_t'(1);
    if (pop)  fifo_rd_d = fifo_rd_q + ptr_t'(1);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      ifq_wr_d   = '0;
      ifq_rd_d   = '0;
      count_d    = '0;
      // Every request still unanswered after this cycle is now stale.
      kill_d     = outstanding_d;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      ifq_wr_q      <= '0;
      ifq_rd_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      ifq_wr_q      <= ifq_wr_d;
      ifq_rd_q      <= ifq_rd_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  // Storage writes: request PCs on grant, returned words into the FIFO.
  always_ff @(posedge clk) begin
    if (grant) ifq_pc_mem[ifq_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_inst_mem[fifo_wr_q] <= imem_rdata;
      fifo_pc_mem[fifo_wr_q]   <= ifq_pc_mem[ifq_rd_q];
    end
  end

endmodule
